// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning one-hot LED decoder: mode encodings,
// FSM state enum and the one-hot decode helper.
package decoder_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_DIRECT  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SCAN_DN = 2'b10;
  localparam logic [MODE_W-1:0] MODE_HOLD    = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_DIRECT  = 3'd1,
    ST_SCAN_UP = 3'd2,
    ST_SCAN_DN = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  // The helper works on the widest supported index; callers truncate the
  // result to their own output width. Selects wider than 8 bits are not
  // supported by this helper.
  localparam int unsigned DEC_MAX_SEL_W = 8;
  localparam int unsigned DEC_MAX_OUT_W = 256;

  // Exactly one bit differs from the rest for every index value.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot_decode(
    input logic [DEC_MAX_SEL_W-1:0] idx,
    input logic                     active_low
  );
    logic [DEC_MAX_OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return active_low ? ~v : v;
  endfunction

  // Maps the mode pins to the state used while the block is enabled.
  function automatic state_e mode_to_state(input logic [MODE_W-1:0] mode);
    state_e s;
    case (mode)
      MODE_DIRECT:  s = ST_DIRECT;
      MODE_SCAN_UP: s = ST_SCAN_UP;
      MODE_SCAN_DN: s = ST_SCAN_DN;
      default:      s = ST_HOLD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decoder_scan_n_tick_gen.sv
// Prescaler producing a one-cycle step strobe every DIV clocks while running.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   clear - restart the count at 0 (has priority over run, suppresses tick)
//   run   - advance the count this cycle
//   tick  - combinational strobe: count is at DIV-1 and advancing
module tick_gen #(
  parameter int unsigned DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == CNT_LAST);
  assign tick    = run & ~clear & at_last;

  // Next count: clear wins, otherwise wrap at DIV-1 while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// SEL_W-to-2^SEL_W one-hot LED decoder with registered outputs, enable
// pattern gating, selectable polarity, and prescaled up/down scan and hold
// modes.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   enable - block active only when equal to EN_PATTERN
//   switch - select index used in DIRECT mode
//   mode   - 00 DIRECT, 01 SCAN_UP, 10 SCAN_DN, 11 HOLD
//   led    - registered decoded output
//   pos    - registered current index
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int unsigned           SEL_W      = 3,
  parameter int unsigned           EN_W       = 3,
  parameter logic [EN_W-1:0]       EN_PATTERN = EN_W'(4),
  parameter bit                    ACTIVE_LOW = 1'b1,
  parameter int unsigned           DIV        = 50000000,
  localparam int unsigned          OUT_W      = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EN_W-1:0]   enable,
  input  logic [SEL_W-1:0]  switch,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  led,
  output logic [SEL_W-1:0]  pos
);

  localparam logic [OUT_W-1:0] LED_OFF = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  state_e             state_q;
  state_e             state_d;
  logic [SEL_W-1:0]   pos_q;
  logic [SEL_W-1:0]   pos_d;
  logic [OUT_W-1:0]   led_q;
  logic [OUT_W-1:0]   led_d;
  logic               presc_clear;
  logic               presc_run;
  logic               step;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
    return OUT_W'(onehot_decode(DEC_MAX_SEL_W'(idx), ACTIVE_LOW));
  endfunction

  // State is resolved from the pins every cycle; any transition is legal.
  always_comb begin
    state_d = ST_OFF;
    if (enable == EN_PATTERN) begin
      state_d = mode_to_state(mode);
    end
  end

  // Prescaler restarts on every state change so the first scan step lands
  // exactly DIV cycles after entering a scan state.
  assign presc_clear = (state_d != state_q);
  assign presc_run   = (state_d == ST_SCAN_UP) || (state_d == ST_SCAN_DN);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (step)
  );

  // Outputs follow the state being entered on this edge, so re-enabling
  // from OFF shows the decoded index immediately.
  always_comb begin
    pos_d = pos_q;
    led_d = led_q;
    case (state_d)
      ST_DIRECT:  pos_d = switch;
      ST_SCAN_UP: if (step) pos_d = pos_q + SEL_W'(1);
      ST_SCAN_DN: if (step) pos_d = pos_q - SEL_W'(1);
      default:    pos_d = pos_q;
    endcase
    // HOLD re-decodes the frozen pos, which matches led unless coming from OFF.
    if (state_d == ST_OFF) begin
      led_d = LED_OFF;
    end else begin
      led_d = decode(pos_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      pos_q   <= '0;
      led_q   <= LED_OFF;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;
  assign pos = pos_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: default build (SEL_W=3, active-low,
// DIV=4) plus a wide active-high build with DIV=1.
module tb_decoder_scan_n;

  logic        clk = 1'b0;
  logic        rst;

  logic [2:0]  enable_a;
  logic [2:0]  switch_a;
  logic [1:0]  mode_a;
  logic [7:0]  led_a;
  logic [2:0]  pos_a;

  logic [2:0]  enable_b;
  logic [3:0]  switch_b;
  logic [1:0]  mode_b;
  logic [15:0] led_b;
  logic [3:0]  pos_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(
    .SEL_W      (3),
    .EN_W       (3),
    .EN_PATTERN (3'b100),
    .ACTIVE_LOW (1'b1),
    .DIV        (4)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .enable (enable_a),
    .switch (switch_a),
    .mode   (mode_a),
    .led    (led_a),
    .pos    (pos_a)
  );

  decoder_scan_n #(
    .SEL_W      (4),
    .EN_W       (3),
    .EN_PATTERN (3'b100),
    .ACTIVE_LOW (1'b0),
    .DIV        (1)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .enable (enable_b),
    .switch (switch_b),
    .mode   (mode_b),
    .led    (led_b),
    .pos    (pos_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_b;
    rst      = 1'b1;
    enable_a = 3'b000;
    switch_a = 3'd0;
    mode_a   = 2'b00;
    enable_b = 3'b000;
    switch_b = 4'd0;
    mode_b   = 2'b00;

    // Reset values
    step();
    chk("rst_led_a", 32'(led_a), 32'h0000_00FF);
    chk("rst_pos_a", 32'(pos_a), 32'd0);
    chk("rst_led_b", 32'(led_b), 32'h0000_0000);
    chk("rst_pos_b", 32'(pos_b), 32'd0);
    #3 rst = 1'b0;

    // DIRECT decode, one-cycle latency
    enable_a = 3'b100; mode_a = 2'b00; switch_a = 3'b101;
    step();
    chk("direct5_led", 32'(led_a), 32'h0000_00DF);
    chk("direct5_pos", 32'(pos_a), 32'd5);
    switch_a = 3'b000;
    step();
    chk("direct0_led", 32'(led_a), 32'h0000_00FE);
    chk("direct0_pos", 32'(pos_a), 32'd0);
    switch_a = 3'b101;
    step();
    chk("direct5b_pos", 32'(pos_a), 32'd5);

    // Wrong enable pattern blanks the bank but keeps pos
    enable_a = 3'b010;
    step();
    chk("off_led", 32'(led_a), 32'h0000_00FF);
    chk("off_pos", 32'(pos_a), 32'd5);
    enable_a = 3'b100; mode_a = 2'b11;
    step();
    chk("hold_reen_led", 32'(led_a), 32'h0000_00DF);
    chk("hold_reen_pos", 32'(pos_a), 32'd5);

    // SCAN_UP from 6 with wrap 7 -> 0
    mode_a = 2'b00; switch_a = 3'd6;
    step();
    chk("direct6_led", 32'(led_a), 32'h0000_00BF);
    mode_a = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("up6_led", 32'(led_a), 32'h0000_00BF);
      chk("up6_pos", 32'(pos_a), 32'd6);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("up7_led", 32'(led_a), 32'h0000_007F);
      chk("up7_pos", 32'(pos_a), 32'd7);
    end
    step();
    chk("upwrap_led", 32'(led_a), 32'h0000_00FE);
    chk("upwrap_pos", 32'(pos_a), 32'd0);

    // SCAN_DN from 0 with wrap 0 -> 7
    mode_a = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dn0_led", 32'(led_a), 32'h0000_00FE);
      chk("dn0_pos", 32'(pos_a), 32'd0);
    end
    step();
    chk("dnwrap_led", 32'(led_a), 32'h0000_007F);
    chk("dnwrap_pos", 32'(pos_a), 32'd7);

    // HOLD mid-scan, then restart scan: next step exactly 4 cycles later
    step();
    step();
    mode_a = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_led", 32'(led_a), 32'h0000_007F);
      chk("hold_pos", 32'(pos_a), 32'd7);
    end
    mode_a = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("restart_pos", 32'(pos_a), 32'd7);
    end
    step();
    chk("restart_step_led", 32'(led_a), 32'h0000_00FE);
    chk("restart_step_pos", 32'(pos_a), 32'd0);

    // Asynchronous reset between edges during a scan
    step();
    step();
    step();
    step();
    chk("prereset_pos", 32'(pos_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_led", 32'(led_a), 32'h0000_00FF);
    chk("async_pos", 32'(pos_a), 32'd0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_led", 32'(led_a), 32'h0000_00FE);
    chk("post_rst_pos", 32'(pos_a), 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_hold", 32'(pos_a), 32'd0);
    step();
    chk("post_rst_step", 32'(led_a), 32'h0000_00FD);

    // Wide active-high build with DIV=1: one step per clock
    enable_b = 3'b100; mode_b = 2'b01;
    step();
    chk("b_entry_led", 32'(led_b), 32'h0000_0001);
    chk("b_entry_pos", 32'(pos_b), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_b = 16'h0001 << (i % 16);
      chk("b_scan_led", 32'(led_b), 32'(exp_b));
      chk("b_scan_pos", 32'(pos_b), 32'(i % 16));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
